// File: rtl/issue_unit_if.sv
// issue_unit_if: registered dispatch bus from the issue unit to RS, LSB and ROB
interface issue_unit_if #(parameter int ROB_POS_W = 4, parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic issue, rs_en, lsb_en, is_store, is_ready, funct7, jump_predict_out;
  logic [ROB_POS_W-1:0] rob_pos;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] imm, rs1_val, rs2_val;
  logic [ROB_POS_W:0] rs1_rob_id, rs2_rob_id;
  modport master(output issue, rs_en, lsb_en, is_store, is_ready, funct7, jump_predict_out, rob_pos, opcode,
                 funct3, rd, pc, imm, rs1_val, rs2_val, rs1_rob_id, rs2_rob_id);
  modport slave(input issue, rs_en, lsb_en, is_store, is_ready, funct7, jump_predict_out, rob_pos, opcode,
                funct3, rd, pc, imm, rs1_val, rs2_val, rs1_rob_id, rs2_rob_id);
endinterface

// File: rtl/issue_unit.sv
// issue_unit: instruction queue whose head is decoded, operand-resolved and dispatched to RS/LSB
module issue_unit #(
  parameter int IQ_DEPTH = 4,
  parameter int NUM_CDB = 2,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rollback,
  input  logic inst_rdy,
  input  logic [31:0] inst,
  input  logic [ADDR_W-1:0] inst_pc,
  input  logic jump_predict,
  output logic iq_full,
  output logic [4:0] reg_rs1,
  output logic [4:0] reg_rs2,
  input  logic [DATA_W-1:0] reg_rs1_val,
  input  logic [DATA_W-1:0] reg_rs2_val,
  input  logic [ROB_POS_W:0] reg_rs1_rob_id,
  input  logic [ROB_POS_W:0] reg_rs2_rob_id,
  output logic [ROB_POS_W-1:0] rob_rs1_pos,
  output logic [ROB_POS_W-1:0] rob_rs2_pos,
  input  logic rob_rs1_ready,
  input  logic rob_rs2_ready,
  input  logic [DATA_W-1:0] rob_rs1_val,
  input  logic [DATA_W-1:0] rob_rs2_val,
  input  logic [ROB_POS_W-1:0] nxt_rob_pos,
  input  logic rob_full,
  input  logic rs_full,
  input  logic lsb_full,
  input  logic [NUM_CDB-1:0] cdb_valid,
  input  logic [NUM_CDB*ROB_POS_W-1:0] cdb_rob_pos,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
  issue_unit_if.master dis
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int RW = ROB_POS_W + 1 + DATA_W;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67, BR = 7'h63,
                         LD = 7'h03, ST = 7'h23, ARITHI = 7'h13, ARITH = 7'h33;
  logic [31:0] q_inst [IQ_DEPTH];
  logic [ADDR_W-1:0] q_pc [IQ_DEPTH];
  logic q_jp [IQ_DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic last_v;
  logic [4:0] last_rd, rd_n;
  logic [ROB_POS_W-1:0] last_pos, pos_n;
  logic [31:0] h, imm;
  logic [6:0] op;
  logic is_l, is_s, is_br, is_jal, is_jalr, is_lui, is_auipc, is_ari, is_arii;
  logic known, to_lsb, use1, use2, deq, fire, enq;
  logic [RW-1:0] r1, r2;

  assign h = q_inst[head];
  assign op = h[6:0];
  assign {is_l, is_s, is_br, is_jal, is_jalr} = {op == LD, op == ST, op == BR, op == JAL, op == JALR};
  assign {is_lui, is_auipc, is_ari, is_arii} = {op == LUI, op == AUIPC, op == ARITH, op == ARITHI};
  assign known = is_l | is_s | is_br | is_jal | is_jalr | is_lui | is_auipc | is_ari | is_arii;
  assign to_lsb = is_l | is_s;
  assign use1 = is_ari | is_arii | is_l | is_s | is_br | is_jalr;
  assign use2 = is_ari | is_s | is_br;
  assign reg_rs1 = h[19:15];
  assign reg_rs2 = h[24:20];
  assign rob_rs1_pos = reg_rs1_rob_id[ROB_POS_W-1:0];
  assign rob_rs2_pos = reg_rs2_rob_id[ROB_POS_W-1:0];
  assign iq_full = count == (PW+1)'(IQ_DEPTH);
  assign enq = inst_rdy && !iq_full && !rollback && rdy;
  // unknown opcodes drain regardless of downstream back-pressure
  assign deq = count != '0 && rdy && !rollback && (!known || (!rob_full && !(to_lsb ? lsb_full : rs_full)));
  assign fire = deq && known;
  assign rd_n = (is_s | is_br) ? 5'd0 : h[11:7];
  // the ROB bumps its tail on the edge where our previous issue is still high
  assign pos_n = dis.issue ? nxt_rob_pos + ROB_POS_W'(1) : nxt_rob_pos;

  always_comb
    imm = (is_lui | is_auipc) ? {h[31:12], 12'b0} :
          is_jal ? {{12{h[31]}}, h[19:12], h[20], h[30:21], 1'b0} :
          (is_jalr | is_l | is_arii) ? {{20{h[31]}}, h[31:20]} :
          is_s ? {{20{h[31]}}, h[31:25], h[11:7]} :
          is_br ? {{20{h[31]}}, h[7], h[30:25], h[11:8], 1'b0} : 32'b0;

  function automatic logic [RW-1:0] resolve(input logic [4:0] idx, input logic used, input logic [ROB_POS_W:0] tag,
                                           input logic [DATA_W-1:0] val, input logic rrdy,
                                           input logic [DATA_W-1:0] rv);
    logic [DATA_W-1:0] cv;
    logic hit;
    cv = '0;
    hit = 1'b0;
    for (int i = NUM_CDB - 1; i >= 0; i--)
      if (cdb_valid[i] && cdb_rob_pos[i*ROB_POS_W +: ROB_POS_W] == tag[ROB_POS_W-1:0]) begin
        hit = 1'b1;
        cv = cdb_val[i*DATA_W +: DATA_W];
      end
    if (idx == 5'd0 || !used) return '0;
    if (last_v && idx == last_rd) return {1'b1, last_pos, {DATA_W{1'b0}}};
    if (!tag[ROB_POS_W]) return {{(ROB_POS_W+1){1'b0}}, val};
    if (rrdy) return {{(ROB_POS_W+1){1'b0}}, rv};
    if (hit) return {{(ROB_POS_W+1){1'b0}}, cv};
    return {tag, {DATA_W{1'b0}}};
  endfunction

  always_comb begin
    r1 = resolve(h[19:15], use1, reg_rs1_rob_id, reg_rs1_val, rob_rs1_ready, rob_rs1_val);
    r2 = resolve(h[24:20], use2, reg_rs2_rob_id, reg_rs2_val, rob_rs2_ready, rob_rs2_val);
  end

  always_ff @(posedge clk)
    if (enq) begin
      q_inst[tail] <= inst;
      q_pc[tail] <= inst_pc;
      q_jp[tail] <= jump_predict;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      last_v <= 1'b0;
      last_rd <= '0;
      last_pos <= '0;
      dis.issue <= 1'b0;
      dis.rs_en <= 1'b0;
      dis.lsb_en <= 1'b0;
      dis.is_store <= 1'b0;
      dis.is_ready <= 1'b0;
      dis.funct7 <= 1'b0;
      dis.jump_predict_out <= 1'b0;
      dis.rob_pos <= '0;
      dis.opcode <= '0;
      dis.funct3 <= '0;
      dis.rd <= '0;
      dis.pc <= '0;
      dis.imm <= '0;
      dis.rs1_val <= '0;
      dis.rs2_val <= '0;
      dis.rs1_rob_id <= '0;
      dis.rs2_rob_id <= '0;
    end else if (!rdy) begin
      dis.issue <= 1'b0;
      dis.rs_en <= 1'b0;
      dis.lsb_en <= 1'b0;
    end else begin
      head <= rollback ? '0 : head + PW'(deq);
      tail <= rollback ? '0 : tail + PW'(enq);
      count <= rollback ? '0 : count + (PW+1)'(enq) - (PW+1)'(deq);
      last_v <= fire;
      dis.issue <= fire;
      dis.rs_en <= fire && !to_lsb;
      dis.lsb_en <= fire && to_lsb;
      if (fire) begin
        last_rd <= rd_n;
        last_pos <= pos_n;
        dis.is_store <= is_s;
        dis.is_ready <= is_s;
        dis.funct7 <= h[30];
        dis.jump_predict_out <= q_jp[head];
        dis.rob_pos <= pos_n;
        dis.opcode <= op;
        dis.funct3 <= h[14:12];
        dis.rd <= rd_n;
        dis.pc <= q_pc[head];
        dis.imm <= imm;
        {dis.rs1_rob_id, dis.rs1_val} <= r1;
        {dis.rs2_rob_id, dis.rs2_val} <= r2;
      end
    end
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: queue-level reference model feeding a scoreboard checked by a negedge monitor
module tb_issue_unit;
  localparam int D = 4, N = 2, RW = 4;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67, BR = 7'h63,
                         LD = 7'h03, ST = 7'h23, ARITHI = 7'h13, ARITH = 7'h33;
  logic clk = 1'b0, rst, rdy, rollback, inst_rdy, jump_predict, iq_full;
  logic [31:0] inst, inst_pc, reg_rs1_val, reg_rs2_val, rob_rs1_val, rob_rs2_val;
  logic [4:0] reg_rs1, reg_rs2, reg_rs1_rob_id, reg_rs2_rob_id;
  logic [RW-1:0] rob_rs1_pos, rob_rs2_pos, nxt_rob_pos;
  logic rob_rs1_ready, rob_rs2_ready, rob_full, rs_full, lsb_full;
  logic [N-1:0] cdb_valid;
  logic [N*RW-1:0] cdb_rob_pos;
  logic [N*32-1:0] cdb_val;
  bit track;
  int checks = 0, errors = 0, n_issue = 0;

  always #5 clk = ~clk;

  issue_unit_if #(.ROB_POS_W(RW), .DATA_W(32), .ADDR_W(32)) dis();

  issue_unit #(.IQ_DEPTH(D), .NUM_CDB(N), .ROB_POS_W(RW), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
    .jump_predict(jump_predict), .iq_full(iq_full), .reg_rs1(reg_rs1), .reg_rs2(reg_rs2),
    .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val), .reg_rs1_rob_id(reg_rs1_rob_id),
    .reg_rs2_rob_id(reg_rs2_rob_id), .rob_rs1_pos(rob_rs1_pos), .rob_rs2_pos(rob_rs2_pos),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready), .rob_rs1_val(rob_rs1_val),
    .rob_rs2_val(rob_rs2_val), .nxt_rob_pos(nxt_rob_pos), .rob_full(rob_full), .rs_full(rs_full),
    .lsb_full(lsb_full), .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .dis(dis));

  typedef struct packed {
    logic rs_en, lsb_en, is_store, is_ready, funct7, jp;
    logic [RW-1:0] pos;
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] pc, imm, v1, v2;
    logic [RW:0] t1, t2;
  } exp_t;
  typedef struct packed { logic [31:0] i, pc; logic jp; } ent_t;

  exp_t expq[$];
  ent_t mq[$];
  bit m_issue, m_lv;
  logic [4:0] m_lrd;
  logic [RW-1:0] m_lpos;

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic [31:0] sx;
    sx = i[31] ? 32'hffff_ffff : 32'h0;
    case (i[6:0])
      LUI, AUIPC: return i & 32'hffff_f000;
      JAL: return (sx << 20) | (i[19:12] << 12) | (i[20] << 11) | (i[30:21] << 1);
      JALR, LD, ARITHI: return (sx << 12) | i[31:20];
      ST: return (sx << 12) | (i[31:25] << 5) | i[11:7];
      BR: return (sx << 12) | (i[7] << 11) | (i[30:25] << 5) | (i[11:8] << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void res(input logic [4:0] idx, input bit used, input logic [RW:0] tag, input logic [31:0] rv,
                              input bit rrdy, input logic [31:0] robv, output logic [31:0] v, output logic [RW:0] t);
    v = 32'h0;
    t = '0;
    if (idx == 0 || !used) return;
    if (m_lv && idx == m_lrd) begin
      t = {1'b1, m_lpos};
      return;
    end
    if (!tag[RW]) begin
      v = rv;
      return;
    end
    if (rrdy) begin
      v = robv;
      return;
    end
    for (int c = 0; c < N; c++)
      if (cdb_valid[c] && cdb_rob_pos[c*RW +: RW] == tag[RW-1:0]) begin
        v = cdb_val[c*32 +: 32];
        return;
      end
    t = tag;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] i;
    logic [6:0] op;
    bit known, lsb, go, pop, ok;
    exp_t x;
    if (rst) begin
      mq.delete();
      expq.delete();
      m_issue = 0;
      m_lv = 0;
    end else if (!rdy) m_issue = 0;
    else begin
      go = 0;
      pop = 0;
      x = '0;
      ok = inst_rdy && !rollback && mq.size() < D;
      if (!rollback && mq.size() > 0) begin
        i = mq[0].i;
        op = i[6:0];
        known = op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, ARITHI, ARITH};
        lsb = op == LD || op == ST;
        pop = !known || (!rob_full && !(lsb ? lsb_full : rs_full));
        go = pop && known;
        if (go) begin
          x.rs_en = !lsb;
          x.lsb_en = lsb;
          x.is_store = op == ST;
          x.is_ready = op == ST;
          x.funct7 = i[30];
          x.jp = mq[0].jp;
          x.pos = nxt_rob_pos + RW'(m_issue);
          x.op = op;
          x.f3 = i[14:12];
          x.rd = (op == ST || op == BR) ? 5'd0 : i[11:7];
          x.pc = mq[0].pc;
          x.imm = imm_of(i);
          res(i[19:15], op inside {ARITH, ARITHI, LD, ST, BR, JALR}, reg_rs1_rob_id, reg_rs1_val, rob_rs1_ready,
              rob_rs1_val, x.v1, x.t1);
          res(i[24:20], op inside {ARITH, ST, BR}, reg_rs2_rob_id, reg_rs2_val, rob_rs2_ready, rob_rs2_val,
              x.v2, x.t2);
          expq.push_back(x);
        end
      end
      if (rollback) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (ok) mq.push_back('{inst, inst_pc, jump_predict});
      end
      m_lv = go;
      m_lrd = x.rd;
      m_lpos = x.pos;
      m_issue = go;
    end
  end

  always @(negedge clk) begin
    exp_t a, x;
    if (!rst) begin
      checks++;
      if (iq_full !== (mq.size() == D)) begin
        errors++;
        $display("FAIL iq_full act=%0b exp=%0b", iq_full, mq.size() == D);
      end
      if (mq.size() > 0) begin
        checks++;
        if ({reg_rs1, reg_rs2} !== {mq[0].i[19:15], mq[0].i[24:20]}) begin
          errors++;
          $display("FAIL reg_idx act=%0h/%0h exp=%0h/%0h", reg_rs1, reg_rs2, mq[0].i[19:15], mq[0].i[24:20]);
        end
      end
      checks++;
      if (dis.issue) begin
        n_issue++;
        a = {dis.rs_en, dis.lsb_en, dis.is_store, dis.is_ready, dis.funct7, dis.jump_predict_out, dis.rob_pos,
             dis.opcode, dis.funct3, dis.rd, dis.pc, dis.imm, dis.rs1_val, dis.rs2_val, dis.rs1_rob_id,
             dis.rs2_rob_id};
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL spurious_issue act=%h exp=none", a);
        end else begin
          x = expq.pop_front();
          if (a !== x) begin
            errors++;
            $display("FAIL dispatch act=%h exp=%h", a, x);
          end
        end
      end else if (expq.size() != 0 || dis.rs_en || dis.lsb_en) begin
        errors++;
        $display("FAIL missed_issue act=issue0 rs_en%0b lsb_en%0b exp=%0d pending", dis.rs_en, dis.lsb_en,
                 expq.size());
        expq.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    bit adv;
    adv = dis.issue;
    @(posedge clk);
    @(negedge clk);
    if (track && adv) nxt_rob_pos = nxt_rob_pos + 1'b1;
  endtask

  task automatic quiet();
    rdy = 1; rollback = 0; inst_rdy = 0; inst = 0; inst_pc = 32'h1000; jump_predict = 0;
    reg_rs1_val = 32'h11; reg_rs2_val = 32'h22; reg_rs1_rob_id = 0; reg_rs2_rob_id = 0;
    rob_rs1_ready = 0; rob_rs2_ready = 0; rob_rs1_val = 0; rob_rs2_val = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; cdb_valid = 0; cdb_rob_pos = 0; cdb_val = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, ARITHI, ARITH, 7'h7f, 7'h0f};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 10)];
    r[11:7] = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    quiet();
    track = 1;
    nxt_rob_pos = 3;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("reset_issue", dis.issue, 0);
    chk("reset_full", iq_full, 0);
    chk("reset_outs", {dis.rs_en, dis.lsb_en, dis.is_store, dis.is_ready, dis.rob_pos, dis.rd, dis.imm,
                       dis.rs1_val, dis.rs1_rob_id}, 0);
    rst = 0;
    inst_rdy = 1; inst = 32'h0050_0093;
    cyc();
    inst = 32'h0010_8133;
    cyc();
    inst_rdy = 0;
    chk("addi_issue", dis.issue, 1);
    chk("addi_rs_en", dis.rs_en, 1);
    chk("addi_imm", dis.imm, 5);
    chk("addi_rd", dis.rd, 1);
    chk("addi_tag", dis.rs1_rob_id, 0);
    chk("addi_pos", dis.rob_pos, 3);
    cyc();
    chk("add_issue", dis.issue, 1);
    chk("add_pos", dis.rob_pos, 4);
    chk("add_tags", {dis.rs1_rob_id, dis.rs2_rob_id}, {5'b10011, 5'b10011});
    repeat (2) cyc();
    rs_full = 1; inst_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      inst = {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13};
      cyc();
      if (k == 3) chk("iq_full_set", iq_full, 1);
    end
    inst_rdy = 0; rs_full = 0; nxt_rob_pos = 14;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("drain_issue", dis.issue, 1);
    end
    chk("wrap_pos", dis.rob_pos, 1);
    chk("wrap_rd", dis.rd, 4);
    cyc();
    chk("fifth_refused", dis.issue, 0);
    cyc();
    reg_rs1_rob_id = 5'b10010; cdb_valid = 2'b11; cdb_rob_pos = {4'd2, 4'd2}; cdb_val = {32'hBB, 32'hAA};
    inst_rdy = 1; inst = {12'd0, 5'd5, 3'd0, 5'd3, 7'h13};
    cyc();
    inst_rdy = 0;
    cyc();
    chk("cdb_issue", dis.issue, 1);
    chk("cdb_val", dis.rs1_val, 32'hAA);
    chk("cdb_tag", dis.rs1_rob_id, 0);
    quiet();
    lsb_full = 1; inst_rdy = 1; inst = 32'h0020_A423;
    cyc();
    inst_rdy = 0;
    repeat (3) begin
      cyc();
      chk("sw_blocked", dis.issue, 0);
    end
    lsb_full = 0;
    cyc();
    chk("sw_issue", {dis.issue, dis.lsb_en, dis.rs_en, dis.is_store, dis.is_ready}, 5'b11011);
    chk("sw_rd", dis.rd, 0);
    chk("sw_imm", dis.imm, 8);
    rs_full = 1; inst_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      inst = {12'(k), 5'd1, 3'd0, 5'd2, 7'h13};
      cyc();
    end
    rollback = 1;
    cyc();
    rollback = 0; inst_rdy = 0; rs_full = 0;
    chk("rb_issue", dis.issue, 0);
    chk("rb_full", iq_full, 0);
    repeat (3) begin
      cyc();
      chk("rb_no_dispatch", dis.issue, 0);
    end
    inst_rdy = 1; inst = 32'h0050_0093;
    cyc();
    inst_rdy = 0;
    cyc();
    chk("rb_refill", dis.issue, 1);
    inst_rdy = 1;
    repeat (2) cyc();
    inst_rdy = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_issue", dis.issue, 0);
    chk("arst_outs", {dis.rob_pos, dis.imm, dis.rd, iq_full}, 0);
    @(negedge clk);
    rst = 0;
    track = 0;
    for (int n = 0; n < 3000; n++) begin
      rdy = $urandom_range(0, 15) != 0;
      rollback = $urandom_range(0, 40) == 0;
      inst_rdy = $urandom_range(0, 2) != 0;
      inst = rand_inst();
      inst_pc = $urandom;
      jump_predict = 1'($urandom);
      rob_full = $urandom_range(0, 5) == 0;
      rs_full = $urandom_range(0, 3) == 0;
      lsb_full = $urandom_range(0, 3) == 0;
      reg_rs1_rob_id = {1'($urandom), 4'($urandom_range(0, 3))};
      reg_rs2_rob_id = {1'($urandom), 4'($urandom_range(0, 3))};
      reg_rs1_val = $urandom; reg_rs2_val = $urandom;
      rob_rs1_ready = $urandom_range(0, 2) == 0; rob_rs2_ready = $urandom_range(0, 2) == 0;
      rob_rs1_val = $urandom; rob_rs2_val = $urandom;
      nxt_rob_pos = 4'($urandom);
      cdb_valid = 2'($urandom);
      cdb_rob_pos = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      cdb_val = {$urandom, $urandom};
      cyc();
    end
    quiet();
    repeat (8) cyc();
    chk("n_issue_nonzero", n_issue > 100, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_unit.md
# issue_unit

Parametrised successor to the combinational decoder: buffers fetched instructions in an IQ_DEPTH-entry circular queue and decodes the head. It resolves operands against the regfile, the ROB, NUM_CDB broadcast channels and the instruction it issued in the previous cycle. It dispatches at most one instruction per cycle to RS or LSB through registered outputs, with back-pressure and rollback flush. It sits between the instruction fetcher and the RS/LSB/ROB.

## Interface
- IQ_DEPTH, 4: instruction queue entries (power of 2, ≥2)
- NUM_CDB, 2: result broadcast channels snooped (ALU, LSB, …)
- ROB_POS_W, 4: ROB index width; operand tags are ROB_POS_W+1 bits, MSB=1 means pending
- DATA_W, 32 / ADDR_W, 32: data and PC widths

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; 0 freezes all state
- rollback  in  1  flush request
- inst_rdy, inst, inst_pc, jump_predict  in  1/32/ADDR_W/1  fetch enqueue
- iq_full  out  1  queue holds IQ_DEPTH entries
- reg_rs1, reg_rs2  out  5  regfile read indices (head instruction)
- reg_rs1_val, reg_rs2_val  in  DATA_W; reg_rs1_rob_id, reg_rs2_rob_id  in  ROB_POS_W+1
- rob_rs1_pos, rob_rs2_pos  out  ROB_POS_W  low bits of regfile tags
- rob_rs1_ready, rob_rs2_ready  in  1; rob_rs1_val, rob_rs2_val  in  DATA_W
- nxt_rob_pos  in  ROB_POS_W  ROB tail
- rob_full, rs_full, lsb_full  in  1  asserted when ≤1 free entry
- cdb_valid  in  NUM_CDB; cdb_rob_pos  in  NUM_CDB*ROB_POS_W; cdb_val  in  NUM_CDB*DATA_W  (channel i at slice i)
- issue, rs_en, lsb_en, is_store, is_ready, funct7, jump_predict_out  out  1  registered
- rob_pos  out  ROB_POS_W; opcode  out  7; funct3  out  3; rd  out  5; pc  out  ADDR_W; imm  out  DATA_W
- rs1_val, rs2_val  out  DATA_W; rs1_rob_id, rs2_rob_id  out  ROB_POS_W+1  registered

## Operation
- Enqueue: inst_rdy && !iq_full && !rollback && rdy writes {inst, pc, jump_predict} at tail; tail and count advance.
- Dispatch condition: count>0 && rdy && !rollback && !rob_full && target unit not full. Target is LSB for load/store and RS for ARITH, ARITHI, JAL, JALR, BR, LUI, AUIPC.
- Unknown opcode: dequeued with no issue.
- On dispatch, head dequeues and outputs register. Fields and imm formats are identical to the current decoder.
- Stores and branches: rd=0.
- Stores: is_ready=1, is_store=1.
- ROB allocation:
  - rob_pos = nxt_rob_pos when issue is currently 0.
  - rob_pos = nxt_rob_pos+1 (mod 2^ROB_POS_W) when issue is currently 1, because the ROB advances its tail on that edge.
- Operand resolution per rs, first match wins:
  1. Index 0 → val 0, tag 0.
  2. Operand unused (rs2 of L/ARITHI/JALR; rs1,rs2 of JAL/LUI/AUIPC) → val 0, tag 0.
  3. Index equals last-issued rd, rd≠0, last valid → tag {1, last rob_pos}, val 0.
  4. Regfile tag MSB=0 → regfile value.
  5. rob_rsX_ready → ROB value.
  6. Lowest-index CDB channel with cdb_valid and matching pos → that cdb_val.
  7. Otherwise → val 0, tag = regfile tag.
- Last-issued record: {rd, rob_pos, valid} is captured on every dispatch. It is cleared to invalid on any cycle with no dispatch, because the regfile then holds that rename.

## Timing
- Reset values: queue empty, head=tail=count=0, last record invalid, all outputs 0.
- Latency: inst_rdy sampled at edge E0 → earliest dispatch at E1 → issue high for the cycle E1–E2.
- Throughput: one instruction per cycle.
- issue is a one-cycle pulse per dispatch; it is 0 on any non-dispatch edge.
- Full queue with simultaneous dequeue: the enqueue is refused (iq_full is taken from registered count); fetch retries.
- Pointers wrap modulo IQ_DEPTH.
- Rollback, sampled at an edge: queue empties, last record cleared, issue/rs_en/lsb_en = 0 on that edge. Concurrent inst_rdy is dropped.
- rdy=0: no enqueue or dispatch, outputs hold, issue forced 0.
- Asynchronous rst mid-operation: immediate return to reset values.

## Test plan
- Reset then enqueue ADDI x1,x0,5 (0x00500093) → issue at E1, rs_en=1, imm=5, rd=1, rs1_rob_id=0, rob_pos=nxt_rob_pos.
- Back-to-back ADDI x1 then ADD x2,x1,x1, nxt_rob_pos=3 static → second issue rob_pos=4, rs1_rob_id=rs2_rob_id=5'b10011.
- Fill 4 entries with rs_full=1 → iq_full=1, 5th inst_rdy refused. Release rs_full → 4 issues on consecutive cycles, rob_pos incrementing and wrapping 15→0.
- Regfile tag 5'b10010, rob not ready, cdb0 and cdb1 both pos 2 with vals 0xAA and 0xBB → rs1_val=0xAA, tag 0.
- SW x2,8(x1) with lsb_full=1 for 3 cycles → no issue. Then issue with lsb_en=1, is_store=1, is_ready=1, rd=0, imm=8.
- Queue holds 3 entries, assert rollback with inst_rdy → next cycle count=0, issue=0, no dispatch until a new enqueue.
